axi4_lite_arbiter: RTL and testbench

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

---
 rtl/axi4_lite_pkg.sv | 18 +
 rtl/axi4_lite_arb_pick.sv | 30 +++
 rtl/axi4_lite_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi4_lite_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_BUSY = 2'd1,
        ST_WR_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi4_lite_arb_pick.sv
// Combinational winner select between two requesters.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise requester 1 always wins.
module axi4_lite_arb_pick
    import axi4_lite_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       any_c,
    output logic       win_c
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        any_c = |req;
        win_c = req[1];
        if (req == 2'b11) begin
            win_c = ~last_gnt;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        any_c = |req;
        win_c = req[1];
    end
`endif

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction outstanding.
// ARB_ROUND_ROBIN_EN selects round-robin instead of fixed m1-first priority.
module axi4_lite_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   m0_ARADDR,
    input  logic                m0_ARVALID,
    input  logic                m0_RREADY,
    input  logic [ADDR_W-1:0]   m0_AWADDR,
    input  logic                m0_AWVALID,
    input  logic [DATA_W-1:0]   m0_WDATA,
    input  logic [DATA_W/8-1:0] m0_WSTRB,
    input  logic                m0_WVALID,
    input  logic                m0_BREADY,
    output logic                m0_ARREADY,
    output logic [DATA_W-1:0]   m0_RDATA,
    output logic [1:0]          m0_RRESP,
    output logic                m0_RVALID,
    output logic                m0_AWREADY,
    output logic                m0_WREADY,
    output logic [1:0]          m0_BRESP,
    output logic                m0_BVALID,

    input  logic [ADDR_W-1:0]   m1_ARADDR,
    input  logic                m1_ARVALID,
    input  logic                m1_RREADY,
    input  logic [ADDR_W-1:0]   m1_AWADDR,
    input  logic                m1_AWVALID,
    input  logic [DATA_W-1:0]   m1_WDATA,
    input  logic [DATA_W/8-1:0] m1_WSTRB,
    input  logic                m1_WVALID,
    input  logic                m1_BREADY,
    output logic                m1_ARREADY,
    output logic [DATA_W-1:0]   m1_RDATA,
    output logic [1:0]          m1_RRESP,
    output logic                m1_RVALID,
    output logic                m1_AWREADY,
    output logic                m1_WREADY,
    output logic [1:0]          m1_BRESP,
    output logic                m1_BVALID,

    output logic [ADDR_W-1:0]   s_ARADDR,
    output logic                s_ARVALID,
    output logic                s_RREADY,
    output logic [ADDR_W-1:0]   s_AWADDR,
    output logic                s_AWVALID,
    output logic [DATA_W-1:0]   s_WDATA,
    output logic [DATA_W/8-1:0] s_WSTRB,
    output logic                s_WVALID,
    output logic                s_BREADY,
    input  logic                s_ARREADY,
    input  logic [DATA_W-1:0]   s_RDATA,
    input  logic [1:0]          s_RRESP,
    input  logic                s_RVALID,
    input  logic                s_AWREADY,
    input  logic                s_WREADY,
    input  logic [1:0]          s_BRESP,
    input  logic                s_BVALID
);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic [1:0] req;
    logic [1:0] rd_req;
    logic       any_c;
    logic       win_c;
    logic       last_gnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_gnt = last_q;
`else
    assign last_gnt = 1'b1;
`endif

    assign rd_req = {m1_ARVALID, m0_ARVALID};
    assign req    = {m1_ARVALID | m1_AWVALID | m1_WVALID,
                     m0_ARVALID | m0_AWVALID | m0_WVALID};

    axi4_lite_arb_pick u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .any_c    (any_c),
        .win_c    (win_c)
    );

    // State, grant and (optionally) last-grant registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Grant in IDLE; release on the closing response handshake.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    gnt_d   = win_c;
                    state_d = rd_req[win_c] ? ST_RD_BUSY : ST_WR_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = win_c;
`endif
                end
            end
            ST_RD_BUSY: begin
                if (s_RVALID && s_RREADY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_BUSY: begin
                if (s_BVALID && s_BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel muxing: only the granted master's active direction is connected.
    always_comb begin
        s_ARADDR   = '0;
        s_ARVALID  = 1'b0;
        s_RREADY   = 1'b0;
        s_AWADDR   = '0;
        s_AWVALID  = 1'b0;
        s_WDATA    = '0;
        s_WSTRB    = '0;
        s_WVALID   = 1'b0;
        s_BREADY   = 1'b0;
        m0_ARREADY = 1'b0;
        m0_RDATA   = '0;
        m0_RRESP   = 2'b00;
        m0_RVALID  = 1'b0;
        m0_AWREADY = 1'b0;
        m0_WREADY  = 1'b0;
        m0_BRESP   = 2'b00;
        m0_BVALID  = 1'b0;
        m1_ARREADY = 1'b0;
        m1_RDATA   = '0;
        m1_RRESP   = 2'b00;
        m1_RVALID  = 1'b0;
        m1_AWREADY = 1'b0;
        m1_WREADY  = 1'b0;
        m1_BRESP   = 2'b00;
        m1_BVALID  = 1'b0;
        case (state_q)
            ST_RD_BUSY: begin
                s_ARADDR  = gnt_q ? m1_ARADDR  : m0_ARADDR;
                s_ARVALID = gnt_q ? m1_ARVALID : m0_ARVALID;
                s_RREADY  = gnt_q ? m1_RREADY  : m0_RREADY;
                if (gnt_q) begin
                    m1_ARREADY = s_ARREADY;
                    m1_RDATA   = s_RDATA;
                    m1_RRESP   = s_RRESP;
                    m1_RVALID  = s_RVALID;
                end else begin
                    m0_ARREADY = s_ARREADY;
                    m0_RDATA   = s_RDATA;
                    m0_RRESP   = s_RRESP;
                    m0_RVALID  = s_RVALID;
                end
            end
            ST_WR_BUSY: begin
                s_AWADDR  = gnt_q ? m1_AWADDR  : m0_AWADDR;
                s_AWVALID = gnt_q ? m1_AWVALID : m0_AWVALID;
                s_WDATA   = gnt_q ? m1_WDATA   : m0_WDATA;
                s_WSTRB   = gnt_q ? m1_WSTRB   : m0_WSTRB;
                s_WVALID  = gnt_q ? m1_WVALID  : m0_WVALID;
                s_BREADY  = gnt_q ? m1_BREADY  : m0_BREADY;
                if (gnt_q) begin
                    m1_AWREADY = s_AWREADY;
                    m1_WREADY  = s_WREADY;
                    m1_BRESP   = s_BRESP;
                    m1_BVALID  = s_BVALID;
                end else begin
                    m0_AWREADY = s_AWREADY;
                    m0_WREADY  = s_WREADY;
                    m0_BRESP   = s_BRESP;
                    m0_BVALID  = s_BVALID;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed table-driven bench for axi4_lite_arbiter plus hand-written read sequences.
`timescale 1ns/1ps
module tb_axi4_lite_arbiter;
    import axi4_lite_pkg::*;

    logic        clk, rst;
    logic [31:0] m0_ARADDR, m0_AWADDR, m0_WDATA, m1_ARADDR, m1_AWADDR, m1_WDATA;
    logic [3:0]  m0_WSTRB, m1_WSTRB;
    logic        m0_ARVALID, m0_RREADY, m0_AWVALID, m0_WVALID, m0_BREADY;
    logic        m1_ARVALID, m1_RREADY, m1_AWVALID, m1_WVALID, m1_BREADY;
    logic        m0_ARREADY, m0_RVALID, m0_AWREADY, m0_WREADY, m0_BVALID;
    logic        m1_ARREADY, m1_RVALID, m1_AWREADY, m1_WREADY, m1_BVALID;
    logic [31:0] m0_RDATA, m1_RDATA;
    logic [1:0]  m0_RRESP, m0_BRESP, m1_RRESP, m1_BRESP;
    logic [31:0] s_ARADDR, s_AWADDR, s_WDATA, s_RDATA;
    logic [3:0]  s_WSTRB;
    logic        s_ARVALID, s_RREADY, s_AWVALID, s_WVALID, s_BREADY;
    logic        s_ARREADY, s_RVALID, s_AWREADY, s_WREADY, s_BVALID;
    logic [1:0]  s_RRESP, s_BRESP;

    axi4_lite_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ARADDR(m0_ARADDR), .m0_ARVALID(m0_ARVALID), .m0_RREADY(m0_RREADY),
        .m0_AWADDR(m0_AWADDR), .m0_AWVALID(m0_AWVALID), .m0_WDATA(m0_WDATA),
        .m0_WSTRB(m0_WSTRB), .m0_WVALID(m0_WVALID), .m0_BREADY(m0_BREADY),
        .m0_ARREADY(m0_ARREADY), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP),
        .m0_RVALID(m0_RVALID), .m0_AWREADY(m0_AWREADY), .m0_WREADY(m0_WREADY),
        .m0_BRESP(m0_BRESP), .m0_BVALID(m0_BVALID),
        .m1_ARADDR(m1_ARADDR), .m1_ARVALID(m1_ARVALID), .m1_RREADY(m1_RREADY),
        .m1_AWADDR(m1_AWADDR), .m1_AWVALID(m1_AWVALID), .m1_WDATA(m1_WDATA),
        .m1_WSTRB(m1_WSTRB), .m1_WVALID(m1_WVALID), .m1_BREADY(m1_BREADY),
        .m1_ARREADY(m1_ARREADY), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP),
        .m1_RVALID(m1_RVALID), .m1_AWREADY(m1_AWREADY), .m1_WREADY(m1_WREADY),
        .m1_BRESP(m1_BRESP), .m1_BVALID(m1_BVALID),
        .s_ARADDR(s_ARADDR), .s_ARVALID(s_ARVALID), .s_RREADY(s_RREADY),
        .s_AWADDR(s_AWADDR), .s_AWVALID(s_AWVALID), .s_WDATA(s_WDATA),
        .s_WSTRB(s_WSTRB), .s_WVALID(s_WVALID), .s_BREADY(s_BREADY),
        .s_ARREADY(s_ARREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .s_RVALID(s_RVALID), .s_AWREADY(s_AWREADY), .s_WREADY(s_WREADY),
        .s_BRESP(s_BRESP), .s_BVALID(s_BVALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected connection phase: idle, or read/write routed to master 0/1.
    typedef enum int {P_IDLE, P_RD0, P_RD1, P_WR0, P_WR1} ph_e;

    typedef struct {
        logic        r;
        logic [4:0]  m0c;   // {ARVALID,RREADY,AWVALID,WVALID,BREADY}
        logic [4:0]  m1c;
        logic [4:0]  sc;    // {ARREADY,RVALID,AWREADY,WREADY,BVALID}
        logic [31:0] araddr0;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        ph_e         ph;
    } vec_t;

    typedef struct packed {
        logic [31:0] s_araddr; logic s_arvalid; logic s_rready;
        logic [31:0] s_awaddr; logic s_awvalid; logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;  logic s_wvalid;  logic s_bready;
        logic m0_arready; logic [31:0] m0_rdata; logic [1:0] m0_rresp; logic m0_rvalid;
        logic m0_awready; logic m0_wready; logic [1:0] m0_bresp; logic m0_bvalid;
        logic m1_arready; logic [31:0] m1_rdata; logic [1:0] m1_rresp; logic m1_rvalid;
        logic m1_awready; logic m1_wready; logic [1:0] m1_bresp; logic m1_bvalid;
    } obs_t;

    localparam logic [4:0] NO = 5'b00000, RD = 5'b11000, WR = 5'b00111;
    localparam logic [4:0] S_AR = 5'b10000, S_R = 5'b01000, S_AW = 5'b00100,
                           S_W = 5'b00010, S_B = 5'b00001;
    localparam logic [31:0] A0 = 32'h8000_0000;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [31:0] ad, input logic [31:0] rd,
                                input logic [1:0] rr, input logic [1:0] br, input ph_e p);
        vec_t v;
        v.r = r; v.m0c = a; v.m1c = b; v.sc = c; v.araddr0 = ad;
        v.rdata = rd; v.rresp = rr; v.bresp = br; v.ph = p;
        return v;
    endfunction

    // Reference routing: what every output must be for a given phase and the current inputs.
    function automatic obs_t model(input ph_e p);
        obs_t e;
        e = '0;
        case (p)
            P_RD0: begin
                e.s_araddr = m0_ARADDR; e.s_arvalid = m0_ARVALID; e.s_rready = m0_RREADY;
                e.m0_arready = s_ARREADY; e.m0_rdata = s_RDATA;
                e.m0_rresp = s_RRESP; e.m0_rvalid = s_RVALID;
            end
            P_RD1: begin
                e.s_araddr = m1_ARADDR; e.s_arvalid = m1_ARVALID; e.s_rready = m1_RREADY;
                e.m1_arready = s_ARREADY; e.m1_rdata = s_RDATA;
                e.m1_rresp = s_RRESP; e.m1_rvalid = s_RVALID;
            end
            P_WR0: begin
                e.s_awaddr = m0_AWADDR; e.s_awvalid = m0_AWVALID; e.s_wdata = m0_WDATA;
                e.s_wstrb = m0_WSTRB; e.s_wvalid = m0_WVALID; e.s_bready = m0_BREADY;
                e.m0_awready = s_AWREADY; e.m0_wready = s_WREADY;
                e.m0_bresp = s_BRESP; e.m0_bvalid = s_BVALID;
            end
            P_WR1: begin
                e.s_awaddr = m1_AWADDR; e.s_awvalid = m1_AWVALID; e.s_wdata = m1_WDATA;
                e.s_wstrb = m1_WSTRB; e.s_wvalid = m1_WVALID; e.s_bready = m1_BREADY;
                e.m1_awready = s_AWREADY; e.m1_wready = s_WREADY;
                e.m1_bresp = s_BRESP; e.m1_bvalid = s_BVALID;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.s_araddr = s_ARADDR; o.s_arvalid = s_ARVALID; o.s_rready = s_RREADY;
        o.s_awaddr = s_AWADDR; o.s_awvalid = s_AWVALID; o.s_wdata = s_WDATA;
        o.s_wstrb = s_WSTRB; o.s_wvalid = s_WVALID; o.s_bready = s_BREADY;
        o.m0_arready = m0_ARREADY; o.m0_rdata = m0_RDATA; o.m0_rresp = m0_RRESP;
        o.m0_rvalid = m0_RVALID; o.m0_awready = m0_AWREADY; o.m0_wready = m0_WREADY;
        o.m0_bresp = m0_BRESP; o.m0_bvalid = m0_BVALID;
        o.m1_arready = m1_ARREADY; o.m1_rdata = m1_RDATA; o.m1_rresp = m1_RRESP;
        o.m1_rvalid = m1_RVALID; o.m1_awready = m1_AWREADY; o.m1_wready = m1_WREADY;
        o.m1_bresp = m1_BRESP; o.m1_bvalid = m1_BVALID;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        {m0_ARVALID, m0_RREADY, m0_AWVALID, m0_WVALID, m0_BREADY} = NO;
        {m1_ARVALID, m1_RREADY, m1_AWVALID, m1_WVALID, m1_BREADY} = NO;
        {s_ARREADY, s_RVALID, s_AWREADY, s_WREADY, s_BVALID} = NO;
        s_RDATA = '0; s_RRESP = RESP_OKAY; s_BRESP = RESP_OKAY;
    endtask

    // Drive a vector just after a rising edge, check mid-cycle, then advance one clock.
    task automatic apply(input vec_t v, input int idx);
        obs_t e, a;
        rst = v.r;
        {m0_ARVALID, m0_RREADY, m0_AWVALID, m0_WVALID, m0_BREADY} = v.m0c;
        {m1_ARVALID, m1_RREADY, m1_AWVALID, m1_WVALID, m1_BREADY} = v.m1c;
        {s_ARREADY, s_RVALID, s_AWREADY, s_WREADY, s_BVALID} = v.sc;
        m0_ARADDR = v.araddr0; s_RDATA = v.rdata; s_RRESP = v.rresp; s_BRESP = v.bresp;
        #2;
        e = model(v.ph);
        a = observe();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL vec%0d (phase %0d): got %h expected %h", idx, int'(v.ph), a, e);
        end
        @(posedge clk);
        #1;
    endtask

    // Single read from m0: one IDLE cycle, then forwarded; response passes through untouched.
    task automatic hand_read(input string name, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [1:0] rresp);
        int lat;
        drive_idle();
        m0_ARADDR = addr; m0_ARVALID = 1'b1; m0_RREADY = 1'b1;
        s_ARREADY = 1'b1; s_RVALID = 1'b1; s_RDATA = rdata; s_RRESP = rresp;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (s_ARVALID === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_latency"}, 64'(lat), 64'(1));
        chk({name, "_araddr"}, 64'(s_ARADDR), 64'(addr));
        chk({name, "_rdata"}, 64'(m0_RDATA), 64'(rdata));
        chk({name, "_rresp"}, 64'(m0_RRESP), 64'(rresp));
        chk({name, "_m1_quiet"}, 64'({m1_ARREADY, m1_RVALID, m1_AWREADY, m1_WREADY, m1_BVALID,
                                      m1_RDATA, m1_RRESP, m1_BRESP}), 64'(0));
        @(posedge clk);
        #1;
        chk({name, "_back_idle"}, 64'({m0_RVALID, m0_ARREADY, s_ARVALID, s_RREADY}), 64'(0));
        drive_idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        m0_ARADDR = A0; m0_AWADDR = 32'h1000_0000; m0_WDATA = 32'h1111_1111; m0_WSTRB = 4'hF;
        m1_ARADDR = 32'h2000_0040; m1_AWADDR = 32'hA000_03F8; m1_WDATA = 32'h41; m1_WSTRB = 4'b0001;
        drive_idle();

        // Reset holds everything quiet, then a single m0 read.
        tbl.push_back(mk(0, RD, WR, S_AR|S_R|S_AW|S_W|S_B, A0, 32'hDEADBEEF, 0, 0, P_IDLE));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, NO, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, NO, S_AR, A0, 0, 0, 0, P_RD0));
        tbl.push_back(mk(1, 5'b01000, NO, S_R, A0, 32'hDEADBEEF, RESP_OKAY, 0, P_RD0));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        // Contention right after reset: m0 read vs m1 write.
        tbl.push_back(mk(0, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
`ifdef ARB_ROUND_ROBIN_EN
        tbl.push_back(mk(1, RD, WR, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, WR, S_AR|S_R, A0, 32'h0BAD_F00D, 0, 0, P_RD0));
        tbl.push_back(mk(1, RD, WR, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, WR, S_AW|S_W|S_B, A0, 0, 0, RESP_OKAY, P_WR1));
        tbl.push_back(mk(1, RD, NO, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, NO, S_AR|S_R, A0, 32'h0000_5555, 0, 0, P_RD0));
`else
        tbl.push_back(mk(1, RD, WR, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, WR, S_AW|S_W, A0, 0, 0, 0, P_WR1));
        tbl.push_back(mk(1, RD, 5'b00001, S_B, A0, 0, 0, RESP_OKAY, P_WR1));
        tbl.push_back(mk(1, RD, NO, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, NO, S_AR|S_R, A0, 32'h0BAD_F00D, 0, 0, P_RD0));
`endif
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        // m1 write: AW accepted first, W two cycles later, then B.
        tbl.push_back(mk(1, NO, WR, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, NO, WR, S_AW, A0, 0, 0, 0, P_WR1));
        tbl.push_back(mk(1, NO, 5'b00011, NO, A0, 0, 0, 0, P_WR1));
        tbl.push_back(mk(1, NO, 5'b00011, S_W, A0, 0, 0, 0, P_WR1));
        tbl.push_back(mk(1, NO, 5'b00001, NO, A0, 0, 0, 0, P_WR1));
        tbl.push_back(mk(1, NO, 5'b00001, S_B, A0, 0, 0, RESP_OKAY, P_WR1));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        // m0 read stalled on RREADY for five cycles while m1 waits.
        tbl.push_back(mk(1, 5'b10000, NO, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, 5'b10000, RD, S_AR, A0, 0, 0, 0, P_RD0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, NO, RD, S_R, A0, 32'h1234_5678, 0, 0, P_RD0));
        tbl.push_back(mk(1, 5'b01000, RD, S_R, A0, 32'h1234_5678, 0, 0, P_RD0));
        tbl.push_back(mk(1, NO, RD, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, NO, RD, S_AR|S_R, A0, 32'hCAFE_F00D, RESP_EXOKAY, 0, P_RD1));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        // m0 write ending in SLVERR.
        tbl.push_back(mk(1, WR, NO, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, WR, NO, S_AW|S_W|S_B, A0, 0, 0, RESP_SLVERR, P_WR0));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        // DECERR read to address 0.
        tbl.push_back(mk(1, RD, NO, NO, 32'h0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, RD, NO, S_AR|S_R, 32'h0, 0, RESP_DECERR, 0, P_RD0));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));
        // Reset in the middle of an m1 write, then fresh arbitration.
        tbl.push_back(mk(1, NO, WR, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, NO, WR, S_AW, A0, 0, 0, 0, P_WR1));
        tbl.push_back(mk(0, NO, 5'b00011, S_W, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, NO, 5'b00011, NO, A0, 0, 0, 0, P_IDLE));
        tbl.push_back(mk(1, NO, 5'b00011, S_W|S_B, A0, 0, 0, RESP_OKAY, P_WR1));
        tbl.push_back(mk(1, NO, NO, NO, A0, 0, 0, 0, P_IDLE));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        hand_read("okay_read", 32'h8000_0000, 32'hDEADBEEF, RESP_OKAY);
        hand_read("decerr_read", 32'h0000_0000, 32'h0000_0000, RESP_DECERR);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
